reg_scoreboard: RTL and testbench

Issue-side hazard tracker for the 8-bit, 8-register pipelined core. It sits directly upstream of the register file and watches both of its write ports: port 3 carries single-cycle ALU results, port 4 carries multi-cycle unit results. It records which registers have results still in flight and on which port they will land. It raises a combinational stall when a decoded instruction would read or overwrite such a register, or when the multi-cycle unit has no free slot.

---
 rtl/reg_scoreboard.sv | 104 ++++++++++
 tb/tb_reg_scoreboard.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Issue-side hazard tracker for the 8-register core: tracks in-flight results per
// register and the write port (3 = short, 4 = long) that will retire each one.
module reg_scoreboard #(
  parameter int unsigned MAX_LONG = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [2:0] ra1,
  input  logic [2:0] ra2,
  input  logic       use1,
  input  logic       use2,
  input  logic [2:0] wa,
  input  logic       wr,
  input  logic       long_op,
  input  logic       we3,
  input  logic [2:0] wa3,
  input  logic       we4,
  input  logic [2:0] wa4,
  output logic       stall,
  output logic       issue,
  output logic [7:0] busy,
  output logic [2:0] long_cnt,
  output logic       spurious_wb
);

  logic [7:0] r_busy;
  logic [7:0] r_owner;
  logic [2:0] r_long_cnt;
  logic       r_spurious;

  logic       w_valid3;
  logic       w_valid4;
  logic [7:0] w_clr;
  logic       w_raw1;
  logic       w_raw2;
  logic       w_waw;
  logic       w_struct;
  logic       w_stall;
  logic       w_issue;
  logic       w_long_inc;
  logic       w_bad_wb;

  // A write-back only counts if it lands on a pending register owned by its own port.
  assign w_valid3 = we3 & r_busy[wa3] & ~r_owner[wa3];
  assign w_valid4 = we4 & r_busy[wa4] &  r_owner[wa4];
  assign w_bad_wb = (we3 & ~w_valid3) | (we4 & ~w_valid4);

  always_comb begin
    // NOTE: every bit gets a default before the conditional sets, so no latch is inferred.
    w_clr = '0;
    if (w_valid3) w_clr[wa3] = 1'b1;
    if (w_valid4) w_clr[wa4] = 1'b1;
  end

  // Results landing this cycle are bypassed by the register file, so they no longer block.
  assign w_raw1   = use1 & r_busy[ra1] & ~w_clr[ra1];
  assign w_raw2   = use2 & r_busy[ra2] & ~w_clr[ra2];
  assign w_waw    = wr   & r_busy[wa]  & ~w_clr[wa];
  assign w_struct = wr & long_op & (r_long_cnt == 3'(MAX_LONG)) & ~w_valid4;

  assign w_stall    = issue_valid & (w_raw1 | w_raw2 | w_waw | w_struct);
  assign w_issue    = issue_valid & ~w_stall;
  assign w_long_inc = w_issue & wr & long_op;

  // NOTE: state uses non-blocking assignments; the later bit-level set overrides the
  // vector-wide clear, which gives a new issue priority over a same-cycle retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_owner <= '0;
    end else begin
      r_busy <= r_busy & ~w_clr;
      if (w_issue & wr) begin
        r_busy[wa]  <= 1'b1;
        r_owner[wa] <= long_op;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_long_cnt <= '0;
    end else begin
      case ({w_long_inc, w_valid4})
        2'b10:   r_long_cnt <= r_long_cnt + 3'd1;
        2'b01:   r_long_cnt <= r_long_cnt - 3'd1;
        default: r_long_cnt <= r_long_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_spurious <= 1'b0;
    else if (w_bad_wb) r_spurious <= 1'b1;
  end

  assign stall       = w_stall;
  assign issue       = w_issue;
  assign busy        = r_busy;
  assign long_cnt    = r_long_cnt;
  assign spurious_wb = r_spurious;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, reset corner cases, then random
// traffic checked against a per-register pending/owner model.
module tb_reg_scoreboard;

  localparam int MAX_LONG = 3;

  logic       clk;
  logic       reset;
  logic       issue_valid;
  logic [2:0] ra1, ra2, wa, wa3, wa4;
  logic       use1, use2, wr, long_op, we3, we4;
  logic       stall, issue, spurious_wb;
  logic [7:0] busy;
  logic [2:0] long_cnt;

  reg_scoreboard #(.MAX_LONG(MAX_LONG)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
    .wa(wa), .wr(wr), .long_op(long_op),
    .we3(we3), .wa3(wa3), .we4(we4), .wa4(wa4),
    .stall(stall), .issue(issue), .busy(busy),
    .long_cnt(long_cnt), .spurious_wb(spurious_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic       iv;
    logic [2:0] ra1;
    logic       u1;
    logic [2:0] wa;
    logic       wr;
    logic       lo;
    logic       we3;
    logic [2:0] wa3;
    logic       we4;
    logic [2:0] wa4;
    logic       e_stall;
    logic       e_issue;
    logic [7:0] e_busy;
    logic [2:0] e_cnt;
    logic       e_spur;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [2:0] r1, logic u1, logic [2:0] w, logic wrr,
                              logic lo, logic w3, logic [2:0] a3, logic w4, logic [2:0] a4,
                              logic es, logic ei, logic [7:0] eb, logic [2:0] ec, logic esp);
    vec_t v;
    v.iv = iv; v.ra1 = r1; v.u1 = u1; v.wa = w; v.wr = wrr; v.lo = lo;
    v.we3 = w3; v.wa3 = a3; v.we4 = w4; v.wa4 = a4;
    v.e_stall = es; v.e_issue = ei; v.e_busy = eb; v.e_cnt = ec; v.e_spur = esp;
    return v;
  endfunction

  task automatic idle_inputs();
    issue_valid = 0; ra1 = 0; ra2 = 0; use1 = 0; use2 = 0;
    wa = 0; wr = 0; long_op = 0; we3 = 0; wa3 = 0; we4 = 0; wa4 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  // Reference model: which registers still wait for a result, and on which port.
  bit mb[8];
  int own[8];
  bit mspur;

  function automatic int pending_long();
    int n = 0;
    for (int r = 0; r < 8; r++) if (mb[r] && own[r] == 4) n++;
    return n;
  endfunction

  function automatic logic [7:0] model_busy();
    logic [7:0] b = '0;
    for (int r = 0; r < 8; r++) b[r] = mb[r];
    return b;
  endfunction

  function automatic int pick_pending(int port);
    int cand[$];
    for (int r = 0; r < 8; r++) if (mb[r] && own[r] == port) cand.push_back(r);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  vec_t tbl[$];

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    check("reset_busy", busy, 8'h00);
    check("reset_cnt", long_cnt, 3'd0);
    check("reset_spur", spurious_wb, 1'b0);
    check("reset_stall", stall, 1'b0);

    //            iv r1 u1 wa wr lo we3 a3 we4 a4  st is busy  cnt sp
    tbl.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 8'h04, 0, 0)); // short r2
    tbl.push_back(mk(1, 2, 1, 2, 1, 0, 1, 2, 0, 0, 0, 1, 8'h04, 0, 0)); // dep + bypass, re-set
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 8'h20, 1, 0)); // long r5
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h20, 1, 0));
    tbl.push_back(mk(1, 5, 1, 0, 1, 0, 0, 0, 1, 5, 0, 1, 8'h01, 0, 0)); // r5 lands
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 8'h02, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 8'h0A, 2, 0));
    tbl.push_back(mk(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 1, 8'h1A, 3, 0));
    tbl.push_back(mk(1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1, 0, 8'h1A, 3, 0)); // structural
    tbl.push_back(mk(1, 0, 0, 6, 1, 1, 0, 0, 1, 1, 0, 1, 8'h58, 3, 0)); // slot frees same cycle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 8'h50, 2, 0));
    tbl.push_back(mk(1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 1, 8'hD0, 3, 0)); // long r7
    tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 8'hD0, 3, 0)); // WAW
    tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 1, 7, 0, 1, 8'hD0, 2, 0)); // set beats clear
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 8'h50, 2, 0));
    tbl.push_back(mk(1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 1, 8'h54, 3, 0)); // long r2
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 8'h54, 3, 1)); // wrong port
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h54, 3, 1)); // sticky

    foreach (tbl[i]) begin
      @(negedge clk);
      issue_valid = tbl[i].iv; ra1 = tbl[i].ra1; use1 = tbl[i].u1; ra2 = 0; use2 = 0;
      wa = tbl[i].wa; wr = tbl[i].wr; long_op = tbl[i].lo;
      we3 = tbl[i].we3; wa3 = tbl[i].wa3; we4 = tbl[i].we4; wa4 = tbl[i].wa4;
      #2;
      check($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
      check($sformatf("vec%0d_issue", i), issue, tbl[i].e_issue);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d_cnt", i), long_cnt, tbl[i].e_cnt);
      check($sformatf("vec%0d_spur", i), spurious_wb, tbl[i].e_spur);
    end

    // Asynchronous reset between edges with work in flight.
    @(negedge clk);
    idle_inputs();
    #2 reset = 1;
    #1;
    check("async_busy", busy, 8'h00);
    check("async_cnt", long_cnt, 3'd0);
    check("async_spur", spurious_wb, 1'b0);
    check("async_stall", stall, 1'b0);
    check("async_issue", issue, 1'b0);
    @(negedge clk);
    reset = 0;
    // A result returning after reset has nothing to retire.
    we4 = 1; wa4 = 4;
    @(posedge clk);
    #1;
    check("post_reset_wb_spur", spurious_wb, 1'b1);
    check("post_reset_wb_busy", busy, 8'h00);

    do_reset();
    for (int r = 0; r < 8; r++) begin mb[r] = 0; own[r] = 3; end
    mspur = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      bit land3, land4, hz, e_st, e_is;
      int p;
      @(negedge clk);
      issue_valid = ($urandom_range(0, 3) != 0);
      ra1 = 3'($urandom); ra2 = 3'($urandom);
      use1 = 1'($urandom); use2 = 1'($urandom);
      wa = 3'($urandom); wr = ($urandom_range(0, 3) != 0); long_op = 1'($urandom);
      p = pick_pending(3);
      if (p >= 0 && $urandom_range(0, 2) == 0) begin we3 = 1; wa3 = 3'(p); end
      else if ($urandom_range(0, 60) == 0)      begin we3 = 1; wa3 = 3'($urandom); end
      else                                      begin we3 = 0; wa3 = 3'($urandom); end
      p = pick_pending(4);
      if (p >= 0 && $urandom_range(0, 3) == 0) begin we4 = 1; wa4 = 3'(p); end
      else if ($urandom_range(0, 60) == 0)      begin we4 = 1; wa4 = 3'($urandom); end
      else                                      begin we4 = 0; wa4 = 3'($urandom); end
      #2;
      land3 = we3 && mb[wa3] && own[wa3] == 3;
      land4 = we4 && mb[wa4] && own[wa4] == 4;
      hz = 0;
      if (use1 && mb[ra1] && !(land3 && wa3 == ra1) && !(land4 && wa4 == ra1)) hz = 1;
      if (use2 && mb[ra2] && !(land3 && wa3 == ra2) && !(land4 && wa4 == ra2)) hz = 1;
      if (wr && mb[wa] && !(land3 && wa3 == wa) && !(land4 && wa4 == wa)) hz = 1;
      if (wr && long_op && pending_long() == MAX_LONG && !land4) hz = 1;
      e_st = issue_valid && hz;
      e_is = issue_valid && !hz;
      check("rnd_stall", stall, e_st);
      check("rnd_issue", issue, e_is);
      @(posedge clk);
      if (land3) mb[wa3] = 0;
      if (land4) mb[wa4] = 0;
      if (e_is && wr) begin mb[wa] = 1; own[wa] = long_op ? 4 : 3; end
      if ((we3 && !land3) || (we4 && !land4)) mspur = 1;
      #1;
      check("rnd_busy", busy, model_busy());
      check("rnd_cnt", long_cnt, 3'(pending_long()));
      check("rnd_spur", spurious_wb, mspur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
